menu_countdown: RTL and testbench

MENU_COUNTDOWN -- requirements
Module: menu_countdown

---
 rtl/menu_pkg.sv | 26 ++
 rtl/menu_countdown_if.sv | 26 ++
 rtl/bcd_digit_down.sv | 22 ++
 rtl/menu_countdown.sv | 120 ++++++++++++
 tb/tb_menu_countdown.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/menu_pkg.sv
// Shared definitions for the menu countdown timer: state encoding, BCD digit
// limits and the warning threshold.
package menu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  localparam logic [15:0] WARN_THRESH = 16'h0010;

  // Nibble order matches time_bcd: {min_tens, min_ones, sec_tens, sec_ones}
  localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_MAX = {TENS_MAX, ONES_MAX, TENS_MAX, ONES_MAX};

  function automatic logic [3:0] sat_digit(input logic [3:0] val, input logic [3:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/menu_countdown_if.sv
// Control/status bundle between the menu controller and the countdown timer.
interface menu_countdown_if;

  logic        tick_1s;
  logic        load;
  logic [15:0] load_bcd;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] time_bcd;
  logic        running;
  logic        warn;
  logic        done;
  logic        expired;

  modport master (
    output tick_1s, load, load_bcd, start, pause, clear,
    input  time_bcd, running, warn, done, expired
  );

  modport slave (
    input  tick_1s, load, load_bcd, start, pause, clear,
    output time_bcd, running, warn, done, expired
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; wraps to max_val when decremented at zero.
// borrow flags a zero digit, i.e. a decrement here must also borrow upstream.
module bcd_digit_down (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic [3:0] max_val,
  output logic [3:0] digit,
  output logic       borrow
);

  always_ff @(posedge clk) begin
    if (rst)       digit <= 4'd0;
    else if (load) digit <= load_val;
    else if (dec)  digit <= (digit == 4'd0) ? max_val : digit - 4'd1;
  end

  assign borrow = (digit == 4'd0);

endmodule

// File: rtl/menu_countdown.sv
// MM:SS BCD countdown timer with load/start/pause/clear control, a low-time
// warning and a single-cycle done pulse on reaching 00:00.
module menu_countdown
  import menu_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  menu_countdown_if.slave  bus
);

  localparam logic [3:0] TICK_LAST = 4'(TICK_DIV - 1);

  state_e state, state_n;

  logic [3:0]                  tick_cnt;
  logic                        tick_clr, tick_inc;
  logic                        done_q, done_n;
  logic                        dig_load, dec;
  logic [15:0]                 load_val;
  logic [15:0]                 load_sat;
  logic [NUM_DIGITS-1:0]       en, borrow;
  logic [NUM_DIGITS-1:0][3:0]  digit;
  logic [15:0]                 time_val;
  logic                        time_zero, time_one, tick_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      bcd_digit_down u_dig (
        .clk      (clk),
        .rst      (rst),
        .load     (dig_load),
        .load_val (load_val[4*gi +: 4]),
        .dec      (en[gi]),
        .max_val  (DIGIT_MAX[gi]),
        .digit    (digit[gi]),
        .borrow   (borrow[gi])
      );
    end
  endgenerate

  assign time_val  = digit;
  assign time_zero = &borrow;
  assign time_one  = (time_val == 16'h0001);
  assign tick_wrap = (tick_cnt == TICK_LAST);

  // Borrow ripples upward only through digits that are currently zero
  always_comb begin
    en    = '0;
    en[0] = dec;
    for (int i = 1; i < NUM_DIGITS; i++) en[i] = en[i-1] & borrow[i-1];
  end

  always_comb begin
    load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      load_sat[4*i +: 4] = sat_digit(bus.load_bcd[4*i +: 4], DIGIT_MAX[i]);
  end

  always_comb begin
    state_n  = state;
    dig_load = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    tick_clr = 1'b0;
    tick_inc = 1'b0;
    done_n   = 1'b0;
    if (bus.clear) begin
      dig_load = 1'b1;
      state_n  = ST_IDLE;
    end else if (bus.load) begin
      dig_load = 1'b1;
      load_val = load_sat;
      state_n  = ST_IDLE;
    end else if (bus.pause && state == ST_RUN) begin
      state_n = ST_PAUSE;
    end else if (bus.start && (state == ST_IDLE || state == ST_PAUSE)) begin
      if (time_zero) begin
        state_n = ST_DONE;
        done_n  = 1'b1;
      end else begin
        state_n  = ST_RUN;
        tick_clr = 1'b1;
      end
    end else if (state == ST_RUN && bus.tick_1s) begin
      if (!tick_wrap) begin
        tick_inc = 1'b1;
      end else if (!time_zero) begin
        tick_clr = 1'b1;
        dec      = 1'b1;
        if (time_one) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tick_cnt <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
      if (tick_clr)      tick_cnt <= 4'd0;
      else if (tick_inc) tick_cnt <= tick_cnt + 4'd1;
    end
  end

  assign bus.time_bcd = time_val;
  assign bus.running  = (state == ST_RUN);
  assign bus.warn     = (state == ST_RUN) && (time_val <= WARN_THRESH);
  assign bus.expired  = (state == ST_DONE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_menu_countdown.sv
// Directed bench for menu_countdown: two instances (TICK_DIV 1 and 3), with
// expected outputs queued at drive time and compared after the clock edge.
module tb_menu_countdown;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  menu_countdown_if ifa();
  menu_countdown_if ifb();

  menu_countdown #(.TICK_DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  menu_countdown #(.TICK_DIV(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // control bits: {rst, clear, pause, start, load, tick}
  localparam logic [5:0] N = 6'h00, T = 6'h01, L = 6'h02, S = 6'h04,
                         P = 6'h08, C = 6'h10, R = 6'h20;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [19:0] exp_q[$];
  string       tag_q[$];

  // {time_bcd, running, warn, done, expired}
  function automatic logic [19:0] E(input logic [15:0] t, input logic r, input logic w,
                                    input logic d, input logic x);
    return {t, r, w, d, x};
  endfunction

  function automatic logic [19:0] obs(input bit sel);
    if (sel) return {ifb.time_bcd, ifb.running, ifb.warn, ifb.done, ifb.expired};
    return {ifa.time_bcd, ifa.running, ifa.warn, ifa.done, ifa.expired};
  endfunction

  task automatic drive(input bit sel, input logic [5:0] c, input logic [15:0] v);
    if (sel) begin
      ifb.tick_1s = c[0]; ifb.load = c[1]; ifb.start = c[2];
      ifb.pause = c[3]; ifb.clear = c[4]; ifb.load_bcd = v;
    end else begin
      ifa.tick_1s = c[0]; ifa.load = c[1]; ifa.start = c[2];
      ifa.pause = c[3]; ifa.clear = c[4]; ifa.load_bcd = v;
    end
    rst = c[5];
  endtask

  task automatic step(input bit sel, input logic [5:0] c, input logic [15:0] v,
                      input logic [19:0] e, input string tag);
    logic [19:0] want;
    logic [19:0] got;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    drive(sel, c, v);
    @(negedge clk);
    drive(sel, N, 16'h0000);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    got  = obs(sel);
    total++;
    assert (got === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed time=%h run/warn/done/exp=%b expected time=%h run/warn/done/exp=%b",
             t, got[19:4], got[3:0], want[19:4], want[3:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, R, 16'h0000);
    drive(1'b1, R, 16'h0000);
    repeat (3) @(negedge clk);

    step(0, R, 16'h0000, E(16'h0000, 0, 0, 0, 0), "reset_a");
    step(1, R, 16'h0000, E(16'h0000, 0, 0, 0, 0), "reset_b");
    step(0, N, 16'h0000, E(16'h0000, 0, 0, 0, 0), "idle_a");

    // three-second run to done
    step(0, L, 16'h0003, E(16'h0003, 0, 0, 0, 0), "load_0003");
    step(0, S, 16'h0000, E(16'h0003, 1, 1, 0, 0), "start_0003");
    step(0, T, 16'h0000, E(16'h0002, 1, 1, 0, 0), "tick1_0002");
    step(0, T, 16'h0000, E(16'h0001, 1, 1, 0, 0), "tick2_0001");
    step(0, T, 16'h0000, E(16'h0000, 0, 0, 1, 1), "tick3_done");
    step(0, N, 16'h0000, E(16'h0000, 0, 0, 0, 1), "done_once");
    step(0, T, 16'h0000, E(16'h0000, 0, 0, 0, 1), "tick_in_done");

    // full borrow chain
    step(0, L, 16'h1000, E(16'h1000, 0, 0, 0, 0), "load_1000");
    step(0, S, 16'h0000, E(16'h1000, 1, 0, 0, 0), "start_1000");
    step(0, T, 16'h0000, E(16'h0959, 1, 0, 0, 0), "borrow_0959");
    step(0, T, 16'h0000, E(16'h0958, 1, 0, 0, 0), "dec_0958");

    // warn threshold and pause beating a tick
    step(0, L, 16'h0012, E(16'h0012, 0, 0, 0, 0), "load_0012");
    step(0, S, 16'h0000, E(16'h0012, 1, 0, 0, 0), "start_0012");
    step(0, T, 16'h0000, E(16'h0011, 1, 0, 0, 0), "warn_off_0011");
    step(0, T, 16'h0000, E(16'h0010, 1, 1, 0, 0), "warn_on_0010");
    step(0, P | T, 16'h0000, E(16'h0010, 0, 0, 0, 0), "pause_vs_tick");
    step(0, T, 16'h0000, E(16'h0010, 0, 0, 0, 0), "tick_in_pause");
    step(0, S, 16'h0000, E(16'h0010, 1, 1, 0, 0), "resume");
    step(0, S | T, 16'h0000, E(16'h0009, 1, 1, 0, 0), "start_in_run");

    // saturation, start at zero, start in DONE
    step(0, L, 16'h7A9F, E(16'h5959, 0, 0, 0, 0), "load_sat_5959");
    step(0, C, 16'h0000, E(16'h0000, 0, 0, 0, 0), "clear");
    step(0, S, 16'h0000, E(16'h0000, 0, 0, 1, 1), "start_zero");
    step(0, S, 16'h0000, E(16'h0000, 0, 0, 0, 1), "start_in_done");

    // priority: clear over load, load over start
    step(0, L | S, 16'h0025, E(16'h0025, 0, 0, 0, 0), "load_over_start");
    step(0, C | L, 16'h0030, E(16'h0000, 0, 0, 0, 0), "clear_over_load");

    // reset aborts a run with a coincident final tick
    step(0, L, 16'h0001, E(16'h0001, 0, 0, 0, 0), "load_0001");
    step(0, S, 16'h0000, E(16'h0001, 1, 1, 0, 0), "start_0001");
    step(0, R | T, 16'h0000, E(16'h0000, 0, 0, 0, 0), "rst_abort");
    step(0, N, 16'h0000, E(16'h0000, 0, 0, 0, 0), "no_done_after_rst");

    // divide-by-3 tick with counter restart on resume
    step(1, L, 16'h0002, E(16'h0002, 0, 0, 0, 0), "div3_load");
    step(1, S, 16'h0000, E(16'h0002, 1, 1, 0, 0), "div3_start");
    step(1, T, 16'h0000, E(16'h0002, 1, 1, 0, 0), "div3_t1");
    step(1, T, 16'h0000, E(16'h0002, 1, 1, 0, 0), "div3_t2");
    step(1, T, 16'h0000, E(16'h0001, 1, 1, 0, 0), "div3_t3_dec");
    step(1, T, 16'h0000, E(16'h0001, 1, 1, 0, 0), "div3_t4");
    step(1, P, 16'h0000, E(16'h0001, 0, 0, 0, 0), "div3_pause");
    step(1, S, 16'h0000, E(16'h0001, 1, 1, 0, 0), "div3_resume");
    step(1, T, 16'h0000, E(16'h0001, 1, 1, 0, 0), "div3_r1");
    step(1, T, 16'h0000, E(16'h0001, 1, 1, 0, 0), "div3_r2");
    step(1, T, 16'h0000, E(16'h0000, 0, 0, 1, 1), "div3_r3_done");
    step(1, N, 16'h0000, E(16'h0000, 0, 0, 0, 1), "div3_expired");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
